sync_mc_fifo: RTL and testbench
===============================

SYNC_MC_FIFO -- requirements
Module: sync_mc_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, giving per-channel depth DEPTH = 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter NUM_CH, default 4, number of independent queues (>=2), with CH_W = $clog2(NUM_CH).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port hw_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port sw_rst, input, 1, synchronous clear of pointers and flags.
REQ-007 SHALL have port mem_rst, input, 1, synchronous zeroing of storage.
REQ-008 SHALL have ports wr_ch (input, CH_W), write_enable (input, 1) and wdata (input, DATA_WIDTH): write channel, request and data.
REQ-009 SHALL have ports rd_ch (input, CH_W) and read_enable (input, 1): read channel and request.
REQ-010 SHALL have ports read_data (output, DATA_WIDTH) and read_valid (output, 1): read word and its qualifier.
REQ-011 SHALL have ports afull_value and aempty_value, input, ADDRESS_WIDTH each: thresholds shared by all channels.
REQ-012 SHALL have ports wfull, rdempty, wr_almost_ful and rd_almost_empty, output, NUM_CH each: per-channel status.
REQ-013 SHALL have ports overflow and underflow, output, NUM_CH each: per-channel sticky error flags.
REQ-014 SHALL have port level, output, NUM_CH*(ADDRESS_WIDTH+1): per-channel occupancy, with channel c at bits [c*(ADDRESS_WIDTH+1) +: ADDRESS_WIDTH+1].

Function
REQ-015 SHALL store each channel in its own region of one NUM_CH*DEPTH array, addressed {ch, ptr[ADDRESS_WIDTH-1:0]}.
REQ-016 SHALL keep ADDRESS_WIDTH+1-bit write and read pointers per channel, wrapping modulo 2*DEPTH, with level = wr_ptr - rd_ptr (modular).
REQ-017 SHALL drive wfull[c] = (level==DEPTH), rdempty[c] = (level==0), wr_almost_ful[c] = (level >= afull_value) and rd_almost_empty[c] = (level <= aempty_value), all decoded from registered pointers so they update the cycle after an accepted operation.
REQ-018 SHALL accept a write when write_enable && !wfull[wr_ch], then store wdata and increment wr_ptr[wr_ch].
REQ-019 SHALL treat a write with wfull[wr_ch]=1 as rejected: no storage or pointer change, and overflow[wr_ch] set to 1 and held.
REQ-020 SHALL accept a read when read_enable && !rdempty[rd_ch], then increment rd_ptr[rd_ch], present the word on read_data one cycle later and pulse read_valid=1 for that one cycle.
REQ-021 SHALL treat a read with rdempty[rd_ch]=1 as rejected: read_valid=0 next cycle, read_data holds its last value, and underflow[rd_ch] set to 1 and held.
REQ-022 SHALL evaluate full and empty on pre-edge state: a write to a full channel is rejected even with a simultaneous accepted read of that channel.
REQ-023 SHALL accept a simultaneous read and write on one channel when the level is 1..DEPTH-1, leaving that level unchanged.
REQ-024 SHALL accept a write and a read on different channels in the same cycle independently.
REQ-025 SHALL give sw_rst priority over all requests: zero every pointer, overflow, underflow and read_valid next cycle, while preserving storage and read_data.
REQ-026 SHALL make mem_rst zero the whole array in one cycle, leaving pointers and flags unchanged; writes are ignored that cycle.
REQ-027 SHALL deliver read data in per-channel FIFO order, unaffected by traffic on other channels.

Reset
REQ-028 SHALL, on hw_rst=1, immediately clear pointers, overflow, underflow, read_valid, read_data and storage to 0, giving rdempty=all 1s, wfull=0 and level=0.
REQ-029 SHALL ignore all requests while hw_rst=1 and resume on the first clk edge after deassertion.

Structure
REQ-030 SHALL place default parameters, CH_W computation and the level-slice helper function in package sync_mc_fifo_pkg.
REQ-031 SHALL implement per-channel pointer, flag and sticky-error logic in sub-module sync_mc_fifo_ch_ctrl, generated NUM_CH times; the top holds storage and read_data.

Verification (DATA_WIDTH=32, ADDRESS_WIDTH=3, NUM_CH=4)
REQ-032 SHALL cover: pulse hw_rst mid-traffic -> rdempty=4'b1111, level=0 and read_valid=0 within the reset cycle.
REQ-033 SHALL cover: write 0x100..0x107 to ch1 -> wfull[1]=1; a 9th write -> overflow[1]=1 and level ch1=8; then 8 reads return 0x100..0x107 in order.
REQ-034 SHALL cover: alternately write ch0 0xA0..0xA3 and ch3 0xB0..0xB3 -> reads return each sequence in order, with levels 4 then 0.
REQ-035 SHALL cover: ch2 at level 3 with a simultaneous read and write -> level stays 3; with ch2 full, write plus read -> overflow[2]=1 and level 7.
REQ-036 SHALL cover: read empty ch3 -> underflow[3]=1 and read_valid=0; then sw_rst -> underflow=0 and overflow=0.
REQ-037 SHALL cover: afull_value=6 and aempty_value=2, writing 6 words -> wr_almost_ful=1 at level 6, rd_almost_empty=1 at level <=2.

Source files
------------

// File: rtl/sync_mc_fifo_pkg.sv
// sync_mc_fifo_pkg
// Shared defaults and helpers for the multi-channel synchronous FIFO.
//   DEF_*       : default parameter values for sync_mc_fifo
//   ch_width()  : channel-select width for a given channel count
//   level_lsb() : LSB of one channel's slice within the packed level bus
package sync_mc_fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_CH        = 4;

    // At least one select bit, so a degenerate single-channel build still has a legal port.
    function automatic int ch_width(input int num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

    // Each channel's occupancy is ADDRESS_WIDTH+1 bits wide, so it can represent a full queue.
    function automatic int level_lsb(input int ch, input int address_width);
        return ch * (address_width + 1);
    endfunction

endpackage

// File: rtl/sync_mc_fifo_ch_ctrl.sv
// sync_mc_fifo_ch_ctrl
// Pointer, status-flag and sticky-error logic for one channel.
// Ports:
//   clk, hw_rst          : clock, asynchronous active-high reset
//   sw_rst               : synchronous clear of pointers and error flags
//   wr_req, rd_req       : write/read requests already steered to this channel
//   afull_value          : almost-full threshold (level >= value)
//   aempty_value         : almost-empty threshold (level <= value)
//   wr_accept, rd_accept : request accepted this cycle
//   wr_addr, rd_addr     : storage offsets within this channel's region
//   wfull, rdempty       : status flags decoded from the registered pointers
//   almost_full, almost_empty : threshold flags
//   overflow, underflow  : sticky error flags
//   level                : occupancy 0..DEPTH
module sync_mc_fifo_ch_ctrl
    import sync_mc_fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     hw_rst,
    input  logic                     sw_rst,
    input  logic                     wr_req,
    input  logic                     rd_req,
    input  logic [ADDRESS_WIDTH-1:0] afull_value,
    input  logic [ADDRESS_WIDTH-1:0] aempty_value,
    output logic                     wr_accept,
    output logic                     rd_accept,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     wfull,
    output logic                     rdempty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [ADDRESS_WIDTH:0]   level
);

    localparam int                 DEPTH   = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L = DEPTH[ADDRESS_WIDTH:0];

    // The extra MSB distinguishes full from empty when the address bits match.
    logic [ADDRESS_WIDTH:0] wr_ptr;
    logic [ADDRESS_WIDTH:0] rd_ptr;

    assign level        = wr_ptr - rd_ptr;
    assign wfull        = (level == DEPTH_L);
    assign rdempty      = (level == '0);
    assign almost_full  = (level >= {1'b0, afull_value});
    assign almost_empty = (level <= {1'b0, aempty_value});

    // Full/empty come from pre-edge pointers, so a write to a full channel is
    // refused even when the same edge also pops a word from it.
    assign wr_accept = wr_req && !wfull;
    assign rd_accept = rd_req && !rdempty;

    assign wr_addr = wr_ptr[ADDRESS_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDRESS_WIDTH-1:0];

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sw_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept)         wr_ptr    <= wr_ptr + 1'b1;
            if (rd_accept)         rd_ptr    <= rd_ptr + 1'b1;
            if (wr_req && wfull)   overflow  <= 1'b1;
            if (rd_req && rdempty) underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/sync_mc_fifo.sv
// sync_mc_fifo
// NUM_CH independent FIFOs sharing one storage array, one write port and one read port.
// Ports:
//   clk, hw_rst       : clock, asynchronous active-high reset (clears everything)
//   sw_rst            : synchronous clear of pointers, error flags and read_valid
//   mem_rst           : synchronous zeroing of storage; writes ignored that cycle
//   wr_ch, write_enable, wdata : write channel, request, data
//   rd_ch, read_enable         : read channel, request
//   read_data, read_valid      : word popped last cycle and its one-cycle qualifier
//   afull_value, aempty_value  : thresholds shared by all channels
//   wfull, rdempty, wr_almost_ful, rd_almost_empty : per-channel status
//   overflow, underflow        : per-channel sticky errors
//   level                      : per-channel occupancy, ADDRESS_WIDTH+1 bits each
module sync_mc_fifo
    import sync_mc_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int  ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int  NUM_CH        = DEF_NUM_CH,
    localparam int CH_W          = ch_width(NUM_CH)
) (
    input  logic                              clk,
    input  logic                              hw_rst,
    input  logic                              sw_rst,
    input  logic                              mem_rst,
    input  logic [CH_W-1:0]                   wr_ch,
    input  logic                              write_enable,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [CH_W-1:0]                   rd_ch,
    input  logic                              read_enable,
    output logic [DATA_WIDTH-1:0]             read_data,
    output logic                              read_valid,
    input  logic [ADDRESS_WIDTH-1:0]          afull_value,
    input  logic [ADDRESS_WIDTH-1:0]          aempty_value,
    output logic [NUM_CH-1:0]                 wfull,
    output logic [NUM_CH-1:0]                 rdempty,
    output logic [NUM_CH-1:0]                 wr_almost_ful,
    output logic [NUM_CH-1:0]                 rd_almost_empty,
    output logic [NUM_CH-1:0]                 overflow,
    output logic [NUM_CH-1:0]                 underflow,
    output logic [NUM_CH*(ADDRESS_WIDTH+1)-1:0] level
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    // sw_rst outranks every request; mem_rst only blocks writes.
    logic wr_go;
    logic rd_go;
    assign wr_go = write_enable && !sw_rst && !mem_rst;
    assign rd_go = read_enable && !sw_rst;

    logic [NUM_CH-1:0]        wr_accept;
    logic [NUM_CH-1:0]        rd_accept;
    logic [ADDRESS_WIDTH-1:0] wr_addr [NUM_CH];
    logic [ADDRESS_WIDTH-1:0] rd_addr [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sync_mc_fifo_ch_ctrl #(
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_ctrl (
            .clk          (clk),
            .hw_rst       (hw_rst),
            .sw_rst       (sw_rst),
            .wr_req       (wr_go && (wr_ch == CH_W'(c))),
            .rd_req       (rd_go && (rd_ch == CH_W'(c))),
            .afull_value  (afull_value),
            .aempty_value (aempty_value),
            .wr_accept    (wr_accept[c]),
            .rd_accept    (rd_accept[c]),
            .wr_addr      (wr_addr[c]),
            .rd_addr      (rd_addr[c]),
            .wfull        (wfull[c]),
            .rdempty      (rdempty[c]),
            .almost_full  (wr_almost_ful[c]),
            .almost_empty (rd_almost_empty[c]),
            .overflow     (overflow[c]),
            .underflow    (underflow[c]),
            .level        (level[level_lsb(c, ADDRESS_WIDTH) +: ADDRESS_WIDTH+1])
        );
    end

    // Only the addressed channel can accept, so OR-reducing gives the event.
    logic wr_do;
    logic rd_do;
    assign wr_do = |wr_accept;
    assign rd_do = |rd_accept;

    // Channel c owns entries {c, offset}.
    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

    // NOTE: storage carries a reset because both hw_rst and mem_rst must zero
    // it in one cycle; this keeps the array in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            for (int i = 0; i < NUM_CH*DEPTH; i++) mem[i] <= '0;
        end else if (mem_rst) begin
            for (int i = 0; i < NUM_CH*DEPTH; i++) mem[i] <= '0;
        end else if (wr_do) begin
            mem[{wr_ch, wr_addr[wr_ch]}] <= wdata;
        end
    end

    // A read in the mem_rst cycle still returns the pre-zeroing word.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_do;
            if (rd_do) read_data <= mem[{rd_ch, rd_addr[rd_ch]}];
        end
    end

endmodule

// File: tb/tb_sync_mc_fifo.sv
// tb_sync_mc_fifo
// Self-checking bench for sync_mc_fifo (DATA_WIDTH=32, ADDRESS_WIDTH=3, NUM_CH=4).
// The reference keeps one queue per channel plus sticky flags and the last read word.
module tb_sync_mc_fifo;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int NCH   = 4;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             hw_rst;
    logic             sw_rst = 1'b0;
    logic             mem_rst = 1'b0;
    logic [1:0]       wr_ch = '0;
    logic             write_enable = 1'b0;
    logic [DW-1:0]    wdata = '0;
    logic [1:0]       rd_ch = '0;
    logic             read_enable = 1'b0;
    logic [DW-1:0]    read_data;
    logic             read_valid;
    logic [AW-1:0]    afull_value = 3'd7;
    logic [AW-1:0]    aempty_value = 3'd1;
    logic [NCH-1:0]   wfull, rdempty, wr_almost_ful, rd_almost_empty, overflow, underflow;
    logic [NCH*(AW+1)-1:0] level;

    sync_mc_fifo #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .NUM_CH        (NCH)
    ) dut (
        .clk             (clk),
        .hw_rst          (hw_rst),
        .sw_rst          (sw_rst),
        .mem_rst         (mem_rst),
        .wr_ch           (wr_ch),
        .write_enable    (write_enable),
        .wdata           (wdata),
        .rd_ch           (rd_ch),
        .read_enable     (read_enable),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .afull_value     (afull_value),
        .aempty_value    (aempty_value),
        .wfull           (wfull),
        .rdempty         (rdempty),
        .wr_almost_ful   (wr_almost_ful),
        .rd_almost_empty (rd_almost_empty),
        .overflow        (overflow),
        .underflow       (underflow),
        .level           (level)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0]  q_m [NCH][$];
    logic [NCH-1:0] ovf_m = '0;
    logic [NCH-1:0] unf_m = '0;
    logic           rv_m  = 1'b0;
    logic [DW-1:0]  rd_m  = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] lvl_of(input int c);
        return level[c*(AW+1) +: AW+1];
    endfunction

    task automatic check_all();
        int sz;
        for (int c = 0; c < NCH; c++) begin
            sz = q_m[c].size();
            check($sformatf("level[%0d]", c), 64'(lvl_of(c)), 64'(sz));
            check($sformatf("wfull[%0d]", c), 64'(wfull[c]), 64'(sz == DEPTH));
            check($sformatf("rdempty[%0d]", c), 64'(rdempty[c]), 64'(sz == 0));
            check($sformatf("afull[%0d]", c), 64'(wr_almost_ful[c]), 64'(sz >= int'(afull_value)));
            check($sformatf("aempty[%0d]", c), 64'(rd_almost_empty[c]), 64'(sz <= int'(aempty_value)));
            check($sformatf("overflow[%0d]", c), 64'(overflow[c]), 64'(ovf_m[c]));
            check($sformatf("underflow[%0d]", c), 64'(underflow[c]), 64'(unf_m[c]));
        end
        check("read_valid", 64'(read_valid), 64'(rv_m));
        check("read_data", 64'(read_data), 64'(rd_m));
    endtask

    // Apply the FIFO rules to the reference using the pre-edge occupancies.
    task automatic model_step(input logic we, input logic [1:0] wc, input logic [DW-1:0] wd,
                              input logic re, input logic [1:0] rc,
                              input logic swr, input logic memr);
        int  wsz;
        int  rsz;
        bit  w_ok;
        bit  r_ok;
        wsz = q_m[wc].size();
        rsz = q_m[rc].size();
        if (swr) begin
            for (int c = 0; c < NCH; c++) q_m[c].delete();
            ovf_m = '0;
            unf_m = '0;
            rv_m  = 1'b0;
        end else begin
            w_ok = we && !memr && (wsz < DEPTH);
            r_ok = re && (rsz > 0);
            if (we && !memr && wsz == DEPTH) ovf_m[wc] = 1'b1;
            if (re && rsz == 0) unf_m[rc] = 1'b1;
            if (r_ok) begin
                rd_m = q_m[rc].pop_front();
                rv_m = 1'b1;
            end else begin
                rv_m = 1'b0;
            end
            if (w_ok) q_m[wc].push_back(wd);
            if (memr)
                for (int c = 0; c < NCH; c++)
                    for (int i = 0; i < q_m[c].size(); i++) q_m[c][i] = '0;
        end
    endtask

    task automatic model_hw_reset();
        for (int c = 0; c < NCH; c++) q_m[c].delete();
        ovf_m = '0;
        unf_m = '0;
        rv_m  = 1'b0;
        rd_m  = '0;
    endtask

    // One clock: drive at negedge, update reference at posedge, check 1 time unit later.
    task automatic cycle(input logic we, input logic [1:0] wc, input logic [DW-1:0] wd,
                         input logic re, input logic [1:0] rc,
                         input logic swr = 1'b0, input logic memr = 1'b0);
        @(negedge clk);
        write_enable = we;
        wr_ch        = wc;
        wdata        = wd;
        read_enable  = re;
        rd_ch        = rc;
        sw_rst       = swr;
        mem_rst      = memr;
        @(posedge clk);
        model_step(we, wc, wd, re, rc, swr, memr);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [1:0] c, input logic [DW-1:0] d);
        cycle(1'b1, c, d, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] c);
        cycle(1'b0, 2'd0, '0, 1'b1, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        hw_rst = 1'b1;
        #3;
        check_all();
        @(negedge clk);
        hw_rst = 1'b0;

        // ch1: fill, overflow, drain in order
        for (int i = 0; i < 8; i++) wr(2'd1, 32'h100 + i);
        check("ch1_full", 64'(wfull[1]), 64'd1);
        wr(2'd1, 32'h1FF);
        check("ch1_overflow", 64'(overflow[1]), 64'd1);
        check("ch1_level_after_ovf", 64'(lvl_of(1)), 64'd8);
        for (int i = 0; i < 8; i++) begin
            rd(2'd1);
            check("ch1_order", 64'(read_data), 64'(32'h100 + i));
        end

        // ch0 / ch3 interleaved
        for (int i = 0; i < 4; i++) begin
            wr(2'd0, 32'hA0 + i);
            wr(2'd3, 32'hB0 + i);
        end
        check("ch0_level4", 64'(lvl_of(0)), 64'd4);
        check("ch3_level4", 64'(lvl_of(3)), 64'd4);
        for (int i = 0; i < 4; i++) begin
            rd(2'd3);
            check("ch3_order", 64'(read_data), 64'(32'hB0 + i));
            rd(2'd0);
            check("ch0_order", 64'(read_data), 64'(32'hA0 + i));
        end
        check("ch0_level0", 64'(lvl_of(0)), 64'd0);

        // ch2: simultaneous read/write at level 3, then at full
        for (int i = 0; i < 3; i++) wr(2'd2, 32'hC0 + i);
        cycle(1'b1, 2'd2, 32'hC3, 1'b1, 2'd2);
        check("ch2_rw_level3", 64'(lvl_of(2)), 64'd3);
        for (int i = 4; i < 9; i++) wr(2'd2, 32'hC0 + i);
        check("ch2_full", 64'(wfull[2]), 64'd1);
        cycle(1'b1, 2'd2, 32'hDEAD, 1'b1, 2'd2);
        check("ch2_full_rw_ovf", 64'(overflow[2]), 64'd1);
        check("ch2_full_rw_level7", 64'(lvl_of(2)), 64'd7);
        for (int i = 0; i < 7; i++) rd(2'd2);

        // Underflow then sw_rst
        rd(2'd3);
        check("ch3_underflow", 64'(underflow[3]), 64'd1);
        check("ch3_underflow_rv", 64'(read_valid), 64'd0);
        cycle(1'b1, 2'd0, 32'h55, 1'b1, 2'd1, 1'b1, 1'b0);
        check("swrst_underflow", 64'(underflow), 64'd0);
        check("swrst_overflow", 64'(overflow), 64'd0);

        // Thresholds
        afull_value  = 3'd6;
        aempty_value = 3'd2;
        for (int i = 0; i < 6; i++) wr(2'd0, 32'hE0 + i);
        check("afull_at6", 64'(wr_almost_ful[0]), 64'd1);
        check("aempty_at6", 64'(rd_almost_empty[0]), 64'd0);
        for (int i = 0; i < 4; i++) rd(2'd0);
        check("aempty_at2", 64'(rd_almost_empty[0]), 64'd1);

        // mem_rst zeroes stored words, ignores the concurrent write
        wr(2'd1, 32'h77);
        cycle(1'b1, 2'd1, 32'h88, 1'b0, 2'd0, 1'b0, 1'b1);
        rd(2'd1);
        check("memrst_zeroed", 64'(read_data), 64'd0);
        rd(2'd0);
        rd(2'd0);

        // Randomized traffic with an hw_rst pulse in the middle
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) begin
                afull_value  = AW'($urandom_range(0, 7));
                aempty_value = AW'($urandom_range(0, 7));
            end
            if (n == 300) begin
                @(negedge clk);
                write_enable = 1'b1;
                read_enable  = 1'b1;
                sw_rst       = 1'b0;
                mem_rst      = 1'b0;
                #2;
                hw_rst = 1'b1;
                #1;
                check("hwrst_rdempty", 64'(rdempty), 64'hF);
                check("hwrst_level", 64'(level), 64'd0);
                check("hwrst_read_valid", 64'(read_valid), 64'd0);
                model_hw_reset();
                check_all();
                @(negedge clk);
                hw_rst       = 1'b0;
                write_enable = 1'b0;
                read_enable  = 1'b0;
                #1;
                check_all();
            end
            cycle(1'($urandom_range(0, 99) < 55), 2'($urandom), $urandom,
                  1'($urandom_range(0, 99) < 45), 2'($urandom),
                  1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
